// File: rtl/bridge_sequencer.sv
// AXI-Lite to APB sequencing control: read/write arbitration, APB setup/access phasing,
// address decode against BASE_HI and a per-access PREADY timeout.
module bridge_sequencer #(
  parameter int unsigned TOUT_CYCLES = 16,
  parameter logic [15:0] BASE_HI     = 16'h4000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID,
  input  logic        WVALID,
  input  logic        ARVALID,
  input  logic        BREADY,
  input  logic        RREADY,
  input  logic [31:0] AWADDR,
  input  logic [31:0] ARADDR,
  input  logic        PREADY,
  input  logic        PSLVERR,
  output logic [2:0]  AXI_next_state,
  output logic [2:0]  APB_next_state,
  output logic        tout,
  output logic        SLVERR_sign,
  output logic        grant_wr
);

  typedef enum logic [2:0] {
    AxiIdle      = 3'd1,
    AxiSendRaddr = 3'd2,
    AxiRdataWait = 3'd3,
    AxiRdataXfer = 3'd4,
    AxiAddrWdata = 3'd5,
    AxiWdataWait = 3'd6,
    AxiWriteEnd  = 3'd7
  } axi_e;

  typedef enum logic [2:0] {
    ApbIdle    = 3'd1,
    ApbRsetup  = 3'd2,
    ApbRaccess = 3'd3,
    ApbWsetup  = 3'd4,
    ApbWaccess = 3'd5
  } apb_e;

  localparam logic [7:0] ToutLimit = 8'(TOUT_CYCLES);

  axi_e       axi_q, axi_d;
  apb_e       apb_q, apb_d;
  logic [7:0] cnt_q, cnt_d;
  logic       tout_q, tout_d;
  logic       slverr_q, slverr_d;
  logic       grant_wr_q, grant_wr_d;
  logic       aw_seen_q, aw_seen_d;
  logic       w_seen_q, w_seen_d;
  logic       prio_wr_q, prio_wr_d;  // 1: write wins the next tie
  logic       access_done;
  logic       rd_pend, wr_pend;

  // Error response and low address bits are handled outside this block.
  logic unused_inputs;
  assign unused_inputs = ^{PSLVERR, AWADDR[15:0], ARADDR[15:0]};

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      axi_q      <= AxiIdle;
      apb_q      <= ApbIdle;
      cnt_q      <= '0;
      tout_q     <= 1'b0;
      slverr_q   <= 1'b0;
      grant_wr_q <= 1'b0;
      aw_seen_q  <= 1'b0;
      w_seen_q   <= 1'b0;
      prio_wr_q  <= 1'b0;
    end else begin
      axi_q      <= axi_d;
      apb_q      <= apb_d;
      cnt_q      <= cnt_d;
      tout_q     <= tout_d;
      slverr_q   <= slverr_d;
      grant_wr_q <= grant_wr_d;
      aw_seen_q  <= aw_seen_d;
      w_seen_q   <= w_seen_d;
      prio_wr_q  <= prio_wr_d;
    end
  end

  always_comb begin
    axi_d       = axi_q;
    apb_d       = apb_q;
    cnt_d       = cnt_q;
    tout_d      = tout_q;
    slverr_d    = slverr_q;
    grant_wr_d  = grant_wr_q;
    aw_seen_d   = aw_seen_q;
    w_seen_d    = w_seen_q;
    prio_wr_d   = prio_wr_q;
    access_done = 1'b0;
    rd_pend     = ARVALID;
    wr_pend     = AWVALID | WVALID;

    case (apb_q)
      ApbIdle:   ;
      ApbRsetup: begin
        apb_d = ApbRaccess;
        cnt_d = '0;
      end
      ApbWsetup: begin
        apb_d = ApbWaccess;
        cnt_d = '0;
      end
      ApbRaccess, ApbWaccess: begin
        // PREADY takes precedence over a timeout landing in the same cycle.
        if (PREADY) begin
          access_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == ToutLimit) begin
            tout_d      = 1'b1;
            access_done = 1'b1;
          end
        end
        if (access_done) apb_d = ApbIdle;
      end
      default: apb_d = ApbIdle;
    endcase

    case (axi_q)
      AxiIdle: begin
        if (rd_pend && (!wr_pend || !prio_wr_q)) begin
          axi_d     = AxiSendRaddr;
          slverr_d  = (ARADDR[31:16] != BASE_HI);
          prio_wr_d = 1'b1;
        end else if (wr_pend) begin
          axi_d      = AxiAddrWdata;
          grant_wr_d = 1'b1;
          prio_wr_d  = 1'b0;
        end
      end
      AxiSendRaddr: begin
        if (slverr_q) begin
          axi_d = AxiRdataXfer;
        end else begin
          axi_d = AxiRdataWait;
          apb_d = ApbRsetup;
        end
      end
      AxiRdataWait: if (access_done) axi_d = AxiRdataXfer;
      AxiRdataXfer: if (RREADY) axi_d = AxiIdle;
      AxiAddrWdata: begin
        if (AWVALID) aw_seen_d = 1'b1;
        if (AWVALID && !aw_seen_q) slverr_d = (AWADDR[31:16] != BASE_HI);
        if (WVALID) w_seen_d = 1'b1;
        if (aw_seen_d && w_seen_d) begin
          if (slverr_d) begin
            axi_d = AxiWriteEnd;
          end else begin
            axi_d = AxiWdataWait;
            apb_d = ApbWsetup;
          end
        end
      end
      AxiWdataWait: if (access_done) axi_d = AxiWriteEnd;
      AxiWriteEnd:  if (BREADY) axi_d = AxiIdle;
      default:      axi_d = AxiIdle;
    endcase

    // Per-transaction status is dropped on every entry to (or stay in) IDLE.
    if (axi_d == AxiIdle) begin
      tout_d     = 1'b0;
      slverr_d   = 1'b0;
      grant_wr_d = 1'b0;
      aw_seen_d  = 1'b0;
      w_seen_d   = 1'b0;
    end
  end

  always_comb begin
    AXI_next_state = axi_q;
    APB_next_state = apb_q;
    tout           = tout_q;
    SLVERR_sign    = slverr_q;
    grant_wr       = grant_wr_q;
  end

endmodule
